i2c_target_regs: RTL and testbench

I2C target (slave) with a small register file for the dice design. It sits between the `uio[2]` (SDA) / `uio[3]` (SCL) pads and the dice core. The bus master writes control registers consumed by the core, and reads back status bytes the core presents (rolled digits, die type). The block oversamples the bus with the system clock, so it has no SCL-clocked logic.

---
 rtl/dice_pkg.sv | 26 ++
 rtl/i2c_sync_edge.sv | 49 ++++
 rtl/i2c_target_regs.sv | 184 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared constants, FSM state type and byte-select helper for the dice
// design's I2C target register block.
package dice_pkg;

    localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h70;
    localparam int         NUM_CTRL         = 4;
    localparam int         NUM_STAT         = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes the raw SCL/SDA pads into the system clock domain and derives
// SCL edges plus START/STOP bus conditions.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Pipes reset to the idle-bus level so leaving reset never fakes a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe[0] <= scl_in;
            sda_pipe[0] <= sda_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_pipe[i] <= scl_pipe[i-1];
                sda_pipe[i] <= sda_pipe[i-1];
            end
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_s     = scl_pipe[SYNC_STAGES-1];
    assign sda_s     = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with four writable control registers and four read-only status
// registers, oversampling the bus with the system clock.
module i2c_target_regs
    import dice_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = I2C_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [8*NUM_CTRL-1:0] ctrl_regs,
    input  logic [8*NUM_STAT-1:0] status_in,
    output logic                  wr_strobe,
    output logic [1:0]            wr_idx
);

    logic                  sda_s;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;

    i2c_state_t            state;
    i2c_state_t            state_nx;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_cnt_nx;
    logic [7:0]            shift;
    logic [7:0]            shift_nx;
    logic [2:0]            ptr;
    logic [2:0]            ptr_nx;
    logic                  rw;
    logic                  rw_nx;
    logic                  sda_oe_nx;
    logic [8*NUM_CTRL-1:0] ctrl_nx;
    logic                  wr_strobe_nx;
    logic [1:0]            wr_idx_nx;
    logic [7:0]            rx_byte;
    logic [7:0]            rd_byte;

    i2c_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            ptr       <= 3'd0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            ctrl_regs <= '0;
            wr_strobe <= 1'b0;
            wr_idx    <= 2'd0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shift     <= shift_nx;
            ptr       <= ptr_nx;
            rw        <= rw_nx;
            sda_oe    <= sda_oe_nx;
            ctrl_regs <= ctrl_nx;
            wr_strobe <= wr_strobe_nx;
            wr_idx    <= wr_idx_nx;
        end
    end

    // The bit counter wraps to zero on every 8th rise, so zero also marks
    // "byte complete" in RD and "fresh byte" everywhere else.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shift_nx     = shift;
        sda_oe_nx    = sda_oe;
        ptr_nx       = ptr;
        rw_nx        = rw;
        ctrl_nx      = ctrl_regs;
        wr_strobe_nx = 1'b0;
        wr_idx_nx    = wr_idx;
        rx_byte      = {shift[6:0], sda_s};
        rd_byte      = ptr[2] ? byte_sel(status_in, ptr[1:0]) : byte_sel(ctrl_regs, ptr[1:0]);

        if (!ena) begin
            state_nx  = IDLE;
            sda_oe_nx = 1'b0;
        end else if (start_det) begin
            state_nx   = ADDR;
            bit_cnt_nx = 3'd0;
            sda_oe_nx  = 1'b0;
        end else if (stop_det) begin
            state_nx  = IDLE;
            sda_oe_nx = 1'b0;
        end else begin
            case (state)
                ADDR, SUB, WR: begin
                    if (scl_rise) begin
                        shift_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    state_nx = ADDR_ACK;
                                    rw_nx    = rx_byte[0];
                                end else begin
                                    state_nx = WAIT_STOP;
                                end
                            end else if (state == SUB) begin
                                ptr_nx   = rx_byte[2:0];
                                state_nx = SUB_ACK;
                            end else begin
                                if (!ptr[2]) begin
                                    ctrl_nx[{ptr[1:0], 3'b000} +: 8] = rx_byte;
                                    wr_strobe_nx = 1'b1;
                                    wr_idx_nx    = ptr[1:0];
                                end
                                ptr_nx   = ptr + 3'd1;
                                state_nx = WR_ACK;
                            end
                        end
                    end
                end

                // First fall pulls SDA for the ACK slot, second fall releases it.
                ADDR_ACK, SUB_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nx = 1'b1;
                        end else if (state == ADDR_ACK && rw) begin
                            state_nx  = RD;
                            shift_nx  = rd_byte;
                            sda_oe_nx = ~rd_byte[7];
                        end else begin
                            sda_oe_nx = 1'b0;
                            state_nx  = (state == ADDR_ACK) ? SUB : WR;
                        end
                    end
                end

                RD: begin
                    if (scl_rise) begin
                        shift_nx   = {shift[6:0], 1'b0};
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_nx = 1'b0;
                            ptr_nx    = ptr + 3'd1;
                            state_nx  = RD_ACK;
                        end else begin
                            sda_oe_nx = ~shift[7];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_nx = WAIT_STOP;
                    end else if (scl_fall) begin
                        state_nx  = RD;
                        shift_nx  = rd_byte;
                        sda_oe_nx = ~rd_byte[7];
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench for i2c_target_regs: a bit-banged I2C master drives the pads
// while scoreboards check register writes and bytes read back.
module tb_i2c_target_regs;
    import dice_pkg::*;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] ctrl_regs;
    logic [31:0] status_in;
    logic        wr_strobe;
    logic [1:0]  wr_idx;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          oe_cycles     = 0;
    wr_exp_t     exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_data  = 8'h00;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(
        .I2C_ADDR    (7'h70),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .ctrl_regs (ctrl_regs),
        .status_in (status_in),
        .wr_strobe (wr_strobe),
        .wr_idx    (wr_idx)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
        scl_m = scl;
        sda_m = sda;
        waitClk(cycles);
    endtask

    task automatic busStart();
        applyStimulus(scl_m, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 5);
    endtask

    task automatic busStop();
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
    endtask

    task automatic writeBit(input logic b);
        applyStimulus(1'b0, b, 5);
        applyStimulus(1'b1, b, 10);
        applyStimulus(1'b0, b, 5);
    endtask

    task automatic readBit(output logic b);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 5);
        b = sda_line;
        applyStimulus(1'b1, 1'b1, 5);
        applyStimulus(1'b0, 1'b1, 5);
    endtask

    task automatic writeByte(input logic [7:0] data, input logic exp_ack, input string name);
        logic ack;
        for (int i = 7; i >= 0; i--) writeBit(data[i]);
        readBit(ack);
        checkOutput(name, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic readByte(input logic nack);
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) readBit(d[i]);
        rd_data  = d;
        rd_valid = 1'b1;
        @(posedge clk);
        #1 rd_valid = 1'b0;
        @(negedge clk);
        writeBit(nack);
    endtask

    function automatic void pushWrite(input logic [1:0] idx, input logic [7:0] data);
        wr_exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_wr.push_back(e);
    endfunction

    // Write scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            checkOutput("wr_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
            if (exp_wr.size() > 0) begin
                wr_exp_t e;
                e = exp_wr.pop_front();
                checkOutput("wr_idx", {30'd0, wr_idx}, {30'd0, e.idx});
                checkOutput("wr_data", {24'd0, ctrl_regs[{wr_idx, 3'b000} +: 8]}, {24'd0, e.data});
            end
        end
    end

    // Read scoreboard: every byte the master clocks in is compared in order.
    always @(posedge clk) begin
        if (rd_valid) begin
            checkOutput("rd_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
            if (exp_rd.size() > 0) checkOutput("rd_byte", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (sda_oe) oe_cycles++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: bench exceeded its cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int oe_base;
        logic b;

        rst_n     = 1'b0;
        ena       = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        status_in = 32'h4433_2211;
        waitClk(3);
        checkOutput("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("reset_ctrl_regs", ctrl_regs, 32'd0);
        checkOutput("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        checkOutput("reset_wr_idx", {30'd0, wr_idx}, 32'd0);
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        checkOutput("reset_ptr", {29'd0, dut.ptr}, 32'd0);
        rst_n = 1'b1;
        waitClk(5);

        $display("[TB] basic write");
        pushWrite(2'd0, 8'hAA);
        pushWrite(2'd1, 8'h55);
        busStart();
        writeByte(8'hE0, 1'b0, "wr_addr_ack");
        writeByte(8'h00, 1'b0, "wr_sub_ack");
        writeByte(8'hAA, 1'b0, "wr_data0_ack");
        writeByte(8'h55, 1'b0, "wr_data1_ack");
        busStop();
        waitClk(5);
        checkOutput("wr_ctrl_low16", {16'd0, ctrl_regs[15:0]}, 32'h0000_55AA);
        checkOutput("wr_pending_after_write", exp_wr.size(), 32'd0);

        $display("[TB] sequential read");
        pushWrite(2'd0, 8'h33);
        pushWrite(2'd1, 8'hFF);
        busStart();
        writeByte(8'hE0, 1'b0, "setup_addr_ack");
        writeByte(8'h00, 1'b0, "setup_sub_ack");
        writeByte(8'h33, 1'b0, "setup_d0_ack");
        writeByte(8'hFF, 1'b0, "setup_d1_ack");
        busStop();
        foreach (exp_rd[i]) exp_rd.delete(i);
        exp_rd = '{8'h33, 8'hFF, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33};
        busStart();
        writeByte(8'hE0, 1'b0, "rd_waddr_ack");
        writeByte(8'h00, 1'b0, "rd_sub_ack");
        busStart();
        writeByte(8'hE1, 1'b0, "rd_raddr_ack");
        for (int i = 0; i < 8; i++) readByte(1'b0);
        readByte(1'b1);
        busStop();
        waitClk(5);
        checkOutput("rd_pending_after_read", exp_rd.size(), 32'd0);
        checkOutput("rd_ptr_after_wrap", {29'd0, dut.ptr}, 32'd1);
        checkOutput("rd_state_after_stop", 32'(dut.state), 32'(IDLE));

        $display("[TB] wrong address");
        oe_base = oe_cycles;
        busStart();
        writeByte(8'hE2, 1'b1, "bad_addr_nack");
        writeByte(8'h99, 1'b1, "bad_data_nack");
        checkOutput("bad_state", 32'(dut.state), 32'(WAIT_STOP));
        checkOutput("bad_ctrl_before_stop", ctrl_regs, 32'h0000_FF33);
        busStop();
        waitClk(5);
        checkOutput("bad_ctrl_after_stop", ctrl_regs, 32'h0000_FF33);
        checkOutput("bad_sda_driven_cycles", oe_cycles - oe_base, 32'd0);

        $display("[TB] pointer wrap on write");
        pushWrite(2'd0, 8'h02);
        busStart();
        writeByte(8'hE0, 1'b0, "wrap_addr_ack");
        writeByte(8'h07, 1'b0, "wrap_sub_ack");
        writeByte(8'h01, 1'b0, "wrap_reg7_ack");
        writeByte(8'h02, 1'b0, "wrap_reg0_ack");
        busStop();
        waitClk(5);
        checkOutput("wrap_ctrl_regs", ctrl_regs, 32'h0000_FF02);
        checkOutput("wrap_ptr", {29'd0, dut.ptr}, 32'd1);
        checkOutput("wrap_pending", exp_wr.size(), 32'd0);

        $display("[TB] stop mid-byte");
        busStart();
        writeByte(8'hE0, 1'b0, "abort_addr_ack");
        writeByte(8'h01, 1'b0, "abort_sub_ack");
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b1);
        writeBit(1'b0);
        busStop();
        waitClk(5);
        checkOutput("abort_state", 32'(dut.state), 32'(IDLE));
        checkOutput("abort_ctrl_regs", ctrl_regs, 32'h0000_FF02);

        $display("[TB] master NACK");
        exp_rd.push_back(8'h02);
        busStart();
        writeByte(8'hE0, 1'b0, "nack_waddr_ack");
        writeByte(8'h00, 1'b0, "nack_sub_ack");
        busStart();
        writeByte(8'hE1, 1'b0, "nack_raddr_ack");
        readByte(1'b1);
        oe_base = oe_cycles;
        for (int i = 0; i < 9; i++) readBit(b);
        checkOutput("nack_sda_driven_cycles", oe_cycles - oe_base, 32'd0);
        checkOutput("nack_state", 32'(dut.state), 32'(WAIT_STOP));
        checkOutput("nack_line_released", {31'd0, b}, 32'd1);
        busStop();
        waitClk(5);

        $display("[TB] enable low");
        ena = 1'b0;
        oe_base = oe_cycles;
        busStart();
        writeByte(8'hE0, 1'b1, "ena_low_addr_nack");
        busStop();
        checkOutput("ena_low_sda_driven_cycles", oe_cycles - oe_base, 32'd0);
        ena = 1'b1;
        waitClk(5);

        $display("[TB] reset during read");
        busStart();
        writeByte(8'hE0, 1'b0, "rst_waddr_ack");
        writeByte(8'h00, 1'b0, "rst_sub_ack");
        busStart();
        writeByte(8'hE1, 1'b0, "rst_raddr_ack");
        waitClk(2);
        checkOutput("rst_pre_sda_oe", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_sda_oe", {31'd0, sda_oe}, 32'd0);
        checkOutput("rst_async_ctrl_regs", ctrl_regs, 32'd0);
        waitClk(3);
        rst_n = 1'b1;
        waitClk(3);
        busStop();
        waitClk(5);
        checkOutput("rst_state_after_stop", 32'(dut.state), 32'(IDLE));
        checkOutput("rst_ptr", {29'd0, dut.ptr}, 32'd0);

        waitClk(5);
        checkOutput("final_wr_pending", exp_wr.size(), 32'd0);
        checkOutput("final_rd_pending", exp_rd.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
